// File: rtl/maxpool_unit.sv
// Max-pool datapath: address stream -> 1-cycle SRAM read -> signed max per window -> FWFT output FIFO.
// Latency 2 cycles from accepted pack beat to OUT_VALID; backpressure is applied only upstream via UP_EN.
module maxpool_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         BIAS_VALID,
    input  logic [ADDR_WIDTH-1:0]        BIAS,
    input  logic                         BIAS_PACK,
    input  logic                         BIAS_LAST,
    output logic                         UP_EN,
    output logic                         RD_EN,
    output logic [ADDR_WIDTH-1:0]        RD_ADDR,
    input  logic signed [DATA_WIDTH-1:0] RD_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic signed [DATA_WIDTH-1:0] OUT_DATA,
    output logic                         OUT_LAST,
    output logic                         DONE
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] data;
        logic                         last;
    } entry_t;

    logic                         en_q;
    logic                         r_v_q, r_pack_q, r_last_q;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d, win_max;
    logic                         first_q, first_d;
    logic                         done_q;
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                count_q, count_d;
    entry_t                       mem_q [FIFO_DEPTH];
    entry_t                       head;
    logic                         accept, push, pop;

    // The generator holds its output while EN is low; the registered enable stops a held beat being re-used.
    assign accept  = BIAS_VALID & en_q;
    assign RD_EN   = accept;
    assign RD_ADDR = BIAS;

    assign UP_EN     = (count_q <= CW'(FIFO_DEPTH - 4));
    assign OUT_VALID = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign OUT_DATA  = head.data;
    assign OUT_LAST  = head.last;
    assign DONE      = done_q;
    assign pop       = OUT_VALID & OUT_READY;

    // A last beat without pack still closes the window so a truncated tail is never dropped.
    assign push = r_v_q & (r_pack_q | r_last_q);

    always_comb begin
        win_max = acc_q;
        acc_d   = acc_q;
        first_d = first_q;
        count_d = count_q;
        if (first_q || (RD_DATA > acc_q)) begin
            win_max = RD_DATA;
        end
        if (r_v_q) begin
            acc_d   = win_max;
            first_d = push;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en_q     <= 1'b0;
            r_v_q    <= 1'b0;
            r_pack_q <= 1'b0;
            r_last_q <= 1'b0;
            acc_q    <= '0;
            first_q  <= 1'b1;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            en_q     <= UP_EN;
            r_v_q    <= accept;
            r_pack_q <= accept & BIAS_PACK;
            r_last_q <= accept & BIAS_LAST;
            acc_q    <= acc_d;
            first_q  <= first_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            done_q   <= pop & head.last;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: win_max, last: r_last_q};
        end
    end

endmodule

// File: tb/tb_maxpool_unit.sv
// Randomized self-checking bench for maxpool_unit: generator/SRAM models plus a window-level max reference.
module tb_maxpool_unit;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic                 CLK;
    logic                 RESET_N;
    logic                 BIAS_VALID;
    logic [AW-1:0]        BIAS;
    logic                 BIAS_PACK;
    logic                 BIAS_LAST;
    logic                 UP_EN;
    logic                 RD_EN;
    logic [AW-1:0]        RD_ADDR;
    logic signed [DW-1:0] RD_DATA;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic signed [DW-1:0] OUT_DATA;
    logic                 OUT_LAST;
    logic                 DONE;

    maxpool_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .BIAS_VALID(BIAS_VALID), .BIAS(BIAS), .BIAS_PACK(BIAS_PACK), .BIAS_LAST(BIAS_LAST),
        .UP_EN(UP_EN), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
        .DONE(DONE)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic          p;
        logic          l;
    } beat_t;

    typedef struct {
        logic signed [DW-1:0] d;
        logic                 l;
    } res_t;

    logic signed [DW-1:0] sram [0:4095];
    beat_t gq[$];
    res_t  eq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int out_cnt = 0;
    int done_cnt = 0;
    int pack_cyc = -1;
    int ov_cyc = -1;
    int occ = 0;
    bit up_prev = 1'b1;
    bit up_low_seen = 1'b0;
    bit a1 = 1'b0, a2 = 1'b0, p1 = 1'b0, done_exp = 1'b0;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (RD_EN) RD_DATA <= sram[RD_ADDR];
    end

    // Generator model: output register advances only on edges where EN was high.
    initial begin
        beat_t b;
        BIAS_VALID = 1'b0;
        BIAS = '0;
        BIAS_PACK = 1'b0;
        BIAS_LAST = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET_N) begin
                BIAS_VALID = 1'b0;
            end else if (up_prev) begin
                if (gq.size() > 0) begin
                    b = gq.pop_front();
                    BIAS = b.a;
                    BIAS_PACK = b.p;
                    BIAS_LAST = b.l;
                    BIAS_VALID = 1'b1;
                end else begin
                    BIAS_VALID = 1'b0;
                end
            end
        end
    end

    // Monitor: occupancy = pack beats accepted two cycles back minus pops, compared every cycle.
    always @(negedge CLK) begin
        bit acc_now, pop_now;
        res_t e;
        if (!RESET_N) begin
            occ = 0; a1 = 0; a2 = 0; p1 = 0; done_exp = 0;
            up_prev = 1'b1;
        end else begin
            acc_now = BIAS_VALID & up_prev;
            check_eq("rd_en", RD_EN, acc_now);
            if (acc_now) check_eq("rd_addr", RD_ADDR, BIAS);
            if (RD_EN) rd_cnt++;
            if (acc_now && (BIAS_PACK || BIAS_LAST) && pack_cyc < 0) pack_cyc = cyc;
            if (OUT_VALID && ov_cyc < 0) ov_cyc = cyc;
            occ = occ + int'(a2) - int'(p1);
            check_eq("fifo_not_over", occ <= DEPTH, 1);
            check_eq("out_valid", OUT_VALID, occ != 0);
            check_eq("up_en", UP_EN, occ <= DEPTH - 4);
            check_eq("done", DONE, done_exp);
            if (DONE) done_cnt++;
            if (!UP_EN) up_low_seen = 1'b1;
            pop_now = OUT_VALID & OUT_READY;
            if (pop_now) begin
                if (eq.size() == 0) begin
                    check_eq("unexpected_out", OUT_DATA, 32'sh7fff_ffff);
                end else begin
                    e = eq.pop_front();
                    check_eq("out_data", OUT_DATA, e.d);
                    check_eq("out_last", OUT_LAST, e.l);
                end
                out_cnt++;
            end
            done_exp = pop_now & OUT_LAST;
            a2 = a1;
            a1 = acc_now & (BIAS_PACK | BIAS_LAST);
            p1 = pop_now;
            up_prev = UP_EN;
        end
    end

    // Reference: expected result per window is the signed max of its elements.
    task automatic pool_frame(input int h, input int w, input int k, input int base);
        int a;
        bit pk, ls;
        logic signed [DW-1:0] m;
        for (int wr = 0; wr < h / k; wr++) begin
            for (int wc = 0; wc < w / k; wc++) begin
                m = sram[base + wr * k * w + wc * k];
                ls = 1'b0;
                for (int i = 0; i < k; i++) begin
                    for (int j = 0; j < k; j++) begin
                        a = base + (wr * k + i) * w + wc * k + j;
                        if (sram[a] > m) m = sram[a];
                        pk = (i == k - 1) && (j == k - 1);
                        ls = pk && (wr == h / k - 1) && (wc == w / k - 1);
                        gq.push_back('{a: AW'(a), p: pk, l: ls});
                    end
                end
                eq.push_back('{d: m, l: ls});
            end
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0;
        out_cnt = 0;
        done_cnt = 0;
        up_low_seen = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget);
        int k = 0;
        while (out_cnt < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        check_eq("wait_outs", out_cnt, n);
        repeat (3) @(posedge CLK);
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        gq.delete();
        eq.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RESET_N = 1'b1;
    endtask

    initial begin
        int k;
        RESET_N = 1'b0;
        OUT_READY = 1'b0;
        #1;
        check_eq("rst_out_valid", OUT_VALID, 0);
        check_eq("rst_up_en", UP_EN, 1);
        check_eq("rst_rd_en", RD_EN, 0);
        check_eq("rst_done", DONE, 0);
        apply_reset();

        // 2x2 pooling of a 4x4 map with SRAM[a] = a-8
        for (int i = 0; i < 16; i++) sram[i] = DW'(i - 8);
        clear_counts();
        pack_cyc = -1;
        ov_cyc = -1;
        OUT_READY = 1'b1;
        pool_frame(4, 4, 2, 0);
        wait_outs(4, 200);
        check_eq("t1_latency", ov_cyc - pack_cyc, 2);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_rd_cnt", rd_cnt, 16);

        // all-negative single window
        sram[100] = -16'sd100; sram[101] = -16'sd7; sram[102] = -16'sd50; sram[103] = -16'sd9;
        clear_counts();
        pool_frame(2, 2, 2, 100);
        wait_outs(1, 100);
        check_eq("t2_done_cnt", done_cnt, 1);

        // 1x1 windows with the consumer stalled: UP_EN must throttle the generator
        for (int i = 0; i < 10; i++) sram[200 + i] = DW'($urandom);
        clear_counts();
        OUT_READY = 1'b0;
        pool_frame(1, 10, 1, 200);
        repeat (30) @(posedge CLK);
        check_eq("t3_up_low", up_low_seen, 1);
        check_eq("t3_stalled_reads", rd_cnt, 7);
        check_eq("t3_none_out", out_cnt, 0);
        @(posedge CLK);
        #1 OUT_READY = 1'b1;
        wait_outs(10, 200);
        check_eq("t3_rd_cnt", rd_cnt, 10);
        check_eq("t3_done_cnt", done_cnt, 1);

        // 8x8 map, 2x2 windows, random consumer readiness
        for (int i = 0; i < 64; i++) sram[300 + i] = DW'($urandom);
        clear_counts();
        pool_frame(8, 8, 2, 300);
        k = 0;
        while (out_cnt < 16 && k < 2000) begin
            @(posedge CLK);
            #1 OUT_READY = 1'($urandom_range(0, 1));
            k++;
        end
        #1 OUT_READY = 1'b1;
        wait_outs(16, 50);
        check_eq("t4_rd_cnt", rd_cnt, 64);
        check_eq("t4_done_cnt", done_cnt, 1);

        // reset after two elements of window 0; the discarded partial holds large values
        for (int i = 0; i < 16; i++) sram[400 + i] = DW'(30000 - i);
        clear_counts();
        pool_frame(4, 4, 2, 400);
        k = 0;
        while (rd_cnt < 2 && k < 100) begin
            @(posedge CLK);
            k++;
        end
        check_eq("t5_wait_rd", rd_cnt >= 2, 1);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check_eq("t5_rst_out_valid", OUT_VALID, 0);
        check_eq("t5_rst_rd_en", RD_EN, 0);
        check_eq("t5_rst_up_en", UP_EN, 1);
        check_eq("t5_rst_done", DONE, 0);
        apply_reset();
        for (int i = 0; i < 16; i++) sram[400 + i] = DW'(-1000 + 3 * i - ((i % 3) * 7));
        clear_counts();
        pool_frame(4, 4, 2, 400);
        wait_outs(4, 200);
        check_eq("t5_done_cnt", done_cnt, 1);

        // truncated final window: last without pack
        sram[500] = 16'sd4; sram[501] = 16'sd9; sram[502] = 16'sd2;
        clear_counts();
        gq.push_back('{a: AW'(500), p: 1'b0, l: 1'b0});
        gq.push_back('{a: AW'(501), p: 1'b0, l: 1'b0});
        gq.push_back('{a: AW'(502), p: 1'b0, l: 1'b1});
        eq.push_back('{d: 16'sd9, l: 1'b1});
        wait_outs(1, 100);
        check_eq("t6_done_cnt", done_cnt, 1);
        check_eq("t6_queue_empty", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
